neuron_bin_feeder: RTL and testbench

- Transmit-side driver for one binary neuron: on `start` it streams `length` activation/weight byte pairs into the neuron's data/valid interface.
- The pairs are fetched from two external synchronous-read RAMs.
- It holds the neuron's length and threshold configuration stable for the whole job, then captures the neuron's 1-bit result.
- It reports `done`, or an error on zero length or on result timeout; it sits between the layer controller/weight store and the neuron.

---
 rtl/neuron_bin_feeder.sv | 195 +++++++++++++++++++
 tb/tb_neuron_bin_feeder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_bin_feeder.sv
// neuron_bin_feeder: transmit-side driver for one binary neuron.
// On an accepted start it reads `length` activation/weight byte pairs from two
// synchronous-read RAMs, streams them to the neuron as contiguous beats, holds
// the neuron's length/threshold configuration for the whole job, then waits
// for the neuron's 1-bit result (or a timeout) and reports done/err.
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   start, length, act_base,      job request and its configuration, sampled
//   wgt_base, threshold_cfg       only when start is accepted in idle
//   act_rd_*, wgt_rd_*            RAM read ports (data valid 1 cycle after en)
//   activ_out, weight_out,        beat stream to the neuron
//   beat_valid
//   in_length_out, threshold_out, neuron configuration, valid for the job
//   threshold_valid
//   result_in, result_valid       neuron result (bit 0 is the answer)
//   busy, done, err, result_bit   job status and captured result
module neuron_bin_feeder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [15:0]        length,
  input  logic [ADDR_W-1:0]  act_base,
  input  logic [ADDR_W-1:0]  wgt_base,
  input  logic signed [31:0] threshold_cfg,
  output logic               act_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  input  logic [7:0]         act_rd_data,
  output logic               wgt_rd_en,
  output logic [ADDR_W-1:0]  wgt_rd_addr,
  input  logic [7:0]         wgt_rd_data,
  output logic [7:0]         activ_out,
  output logic [7:0]         weight_out,
  output logic               beat_valid,
  output logic [15:0]        in_length_out,
  output logic signed [31:0] threshold_out,
  output logic               threshold_valid,
  input  logic [7:0]         result_in,
  input  logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               result_bit
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  // The beat pipeline below is built for a one-cycle RAM read latency only.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("neuron_bin_feeder supports RD_LAT == 1 only");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWaitRes, StFinish} state_e;

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic signed [31:0] thr_q, thr_d;
  logic               job_q, job_d;
  logic [ADDR_W-1:0]  act_addr_q, act_addr_d;
  logic [ADDR_W-1:0]  wgt_addr_q, wgt_addr_d;
  logic [15:0]        rd_cnt_q, rd_cnt_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               res_q, res_d;

  logic               fetch;
  logic               rd_v1_q;   // RAM data valid this cycle
  logic               beat_v_q;
  logic [7:0]         act_q, wgt_q;
  logic               unused_result;

  assign fetch         = (state_q == StFetch);
  assign unused_result = ^result_in[7:1];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    thr_d      = thr_q;
    job_d      = job_q;
    act_addr_d = act_addr_q;
    wgt_addr_d = wgt_addr_q;
    rd_cnt_d   = rd_cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    res_d      = res_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          res_d = 1'b0;
          if (length != 16'd0) begin
            len_d      = length;
            thr_d      = threshold_cfg;
            job_d      = 1'b1;
            act_addr_d = act_base;
            wgt_addr_d = wgt_base;
            rd_cnt_d   = 16'd0;
            err_d      = 1'b0;
            state_d    = StFetch;
          end else begin
            err_d   = 1'b1;
            state_d = StFinish;
          end
        end
      end
      StFetch: begin
        act_addr_d = act_addr_q + 1'b1;
        wgt_addr_d = wgt_addr_q + 1'b1;
        rd_cnt_d   = rd_cnt_q + 16'd1;
        if (rd_cnt_q == len_q - 16'd1) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Once no RAM data is in flight, the last beat is on the output now.
        if (!rd_v1_q) begin
          tmo_d   = '0;
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        if (result_valid) begin
          res_d   = result_in[0];
          err_d   = 1'b0;
          state_d = StFinish;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFinish: begin
        job_d   = 1'b0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      thr_q      <= '0;
      job_q      <= 1'b0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
      rd_cnt_q   <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      res_q      <= 1'b0;
      rd_v1_q    <= 1'b0;
      beat_v_q   <= 1'b0;
      act_q      <= '0;
      wgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      thr_q      <= thr_d;
      job_q      <= job_d;
      act_addr_q <= act_addr_d;
      wgt_addr_q <= wgt_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      res_q      <= res_d;
      rd_v1_q    <= fetch;
      beat_v_q   <= rd_v1_q;
      act_q      <= rd_v1_q ? act_rd_data : 8'd0;
      wgt_q      <= rd_v1_q ? wgt_rd_data : 8'd0;
    end
  end

  assign act_rd_en       = fetch;
  assign wgt_rd_en       = fetch;
  assign act_rd_addr     = fetch ? act_addr_q : '0;
  assign wgt_rd_addr     = fetch ? wgt_addr_q : '0;
  assign activ_out       = act_q;
  assign weight_out      = wgt_q;
  assign beat_valid      = beat_v_q;
  assign in_length_out   = job_q ? len_q : 16'd0;
  assign threshold_out   = job_q ? thr_q : 32'sd0;
  assign threshold_valid = job_q;
  assign busy            = (state_q == StFetch) || (state_q == StDrain) ||
                           (state_q == StWaitRes);
  assign done            = (state_q == StFinish);
  assign err             = done && err_q;
  assign result_bit      = res_q;

endmodule

// File: tb/tb_neuron_bin_feeder.sv
// Self-checking bench for neuron_bin_feeder: a table of jobs with hand-computed
// completion cycle/err/result, per-cycle beat and config checks against a bench
// RAM model, plus hand-written address-wrap and reset-abort sequences.
module tb_neuron_bin_feeder;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 64;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic               start;
  logic [15:0]        length;
  logic [9:0]         act_base, wgt_base;
  logic signed [31:0] threshold_cfg;
  logic               act_rd_en, wgt_rd_en;
  logic [9:0]         act_rd_addr, wgt_rd_addr;
  logic [7:0]         act_rd_data, wgt_rd_data;
  logic [7:0]         activ_out, weight_out;
  logic               beat_valid;
  logic [15:0]        in_length_out;
  logic signed [31:0] threshold_out;
  logic               threshold_valid;
  logic [7:0]         result_in;
  logic               result_valid;
  logic               busy, done, err, result_bit;

  int checks   = 0;
  int failures = 0;

  logic [7:0] act_mem [1024];
  logic [7:0] wgt_mem [1024];
  logic [9:0] addr_log [8];

  always #5 sys_clk = ~sys_clk;

  neuron_bin_feeder #(.ADDR_W(ADDR_W), .RD_LAT(1), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (start),
    .length         (length),
    .act_base       (act_base),
    .wgt_base       (wgt_base),
    .threshold_cfg  (threshold_cfg),
    .act_rd_en      (act_rd_en),
    .act_rd_addr    (act_rd_addr),
    .act_rd_data    (act_rd_data),
    .wgt_rd_en      (wgt_rd_en),
    .wgt_rd_addr    (wgt_rd_addr),
    .wgt_rd_data    (wgt_rd_data),
    .activ_out      (activ_out),
    .weight_out     (weight_out),
    .beat_valid     (beat_valid),
    .in_length_out  (in_length_out),
    .threshold_out  (threshold_out),
    .threshold_valid(threshold_valid),
    .result_in      (result_in),
    .result_valid   (result_valid),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .result_bit     (result_bit)
  );

  // Synchronous-read RAMs, one cycle latency.
  always @(posedge sys_clk) begin
    if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
  end

  typedef struct {
    int         len;
    logic [9:0] abase;
    logic [9:0] wbase;
    logic [31:0] thr;
    bit         respond;
    logic [7:0] res_byte;
    int         restart_at;  // cycle of a second start (0 = none)
    int         noise_at;    // cycle of a stray result_valid (0 = none)
    bit         exp_err;
    bit         exp_res;
    int         exp_done;    // cycle of done, counting the first busy cycle as 1
  } job_t;

  job_t jobs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_job(input job_t j);
    int cyc;
    int nrd = 0;
    int nbeat = 0;
    int first_rd = -1;
    int first_beat = -1;
    int last_beat = -1;
    int done_cyc = -1;
    bit seen_err = 1'b0;
    bit seen_res = 1'b0;
    logic [9:0] ea, ew;
    @(posedge sys_clk); #1;
    start         = 1'b1;
    length        = 16'(j.len);
    act_base      = j.abase;
    wgt_base      = j.wbase;
    threshold_cfg = j.thr;
    @(posedge sys_clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge sys_clk);
      chk("rd_en_pair", {31'd0, wgt_rd_en}, {31'd0, act_rd_en});
      if (act_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        ea = j.abase + 10'(nrd);
        ew = j.wbase + 10'(nrd);
        if (nrd < 8) addr_log[nrd] = act_rd_addr;
        chk("act_rd_addr", act_rd_addr, ea);
        chk("wgt_rd_addr", wgt_rd_addr, ew);
        nrd++;
      end
      if (beat_valid) begin
        if (first_beat < 0) first_beat = cyc;
        chk("beat_contiguous", cyc, first_beat + nbeat);
        ea = j.abase + 10'(nbeat);
        ew = j.wbase + 10'(nbeat);
        chk("activ_out", activ_out, act_mem[ea]);
        chk("weight_out", weight_out, wgt_mem[ew]);
        nbeat++;
        if (nbeat == j.len) last_beat = cyc;
      end else begin
        chk("idle_bytes_zero", {activ_out, weight_out}, 32'd0);
      end
      chk("in_length_out", in_length_out, j.len);
      chk("threshold_out", threshold_out, (j.len != 0) ? j.thr : 32'd0);
      chk("threshold_valid", threshold_valid, j.len != 0);
      chk("busy", busy, (j.len != 0) && !done);
      if (done) begin
        done_cyc = cyc;
        seen_err = err;
        seen_res = result_bit;
      end else begin
        chk("err_without_done", err, 0);
      end
      @(posedge sys_clk); #1;
      cyc++;
      start = (cyc == j.restart_at);
      if (start) length = 16'd20;
      result_valid = (cyc == j.noise_at) || (j.respond && last_beat >= 0 && cyc == last_beat + 4);
      result_in    = (cyc == j.noise_at) ? 8'h01 : j.res_byte;
    end
    start        = 1'b0;
    result_valid = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_cycle", done_cyc, j.exp_done);
    chk("err_at_done", seen_err, j.exp_err);
    chk("result_bit_at_done", seen_res, j.exp_res);
    chk("read_count", nrd, j.len);
    chk("beat_count", nbeat, j.len);
    if (j.len != 0) begin
      chk("first_read_cycle", first_rd, 1);
      chk("first_beat_latency", first_beat, first_rd + 2);
    end
    @(negedge sys_clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("threshold_valid_after", threshold_valid, 0);
    chk("result_bit_held", result_bit, j.exp_res);
  endtask

  logic [9:0] wrap_exp [4];
  int         abort_done;

  initial begin
    //         len abase   wbase   thr    resp res    rst nse err res done
    jobs[0] = '{4, 10'h000, 10'h000, 32'd100,     1'b1, 8'h01, 0, 0, 1'b0, 1'b1, 11};
    jobs[1] = '{2, 10'h010, 10'h020, 32'hFFFFFFFB, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0,
                2 + 3 + TIMEOUT};
    jobs[2] = '{0, 10'h000, 10'h000, 32'd7,       1'b1, 8'h00, 0, 0, 1'b1, 1'b0, 1};
    jobs[3] = '{4, 10'h3FE, 10'h010, 32'd9,       1'b1, 8'hFE, 0, 0, 1'b0, 1'b0, 11};
    jobs[4] = '{1, 10'h005, 10'h006, 32'd0,       1'b1, 8'h03, 0, 0, 1'b0, 1'b1, 8};
    jobs[5] = '{6, 10'h100, 10'h200, 32'd1234,    1'b1, 8'h00, 3, 2, 1'b0, 1'b0, 13};
    wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = 8'(i * 7 + 3);
      wgt_mem[i] = 8'(i ^ 8'h5A);
    end
    act_mem[0] = 8'hFF; act_mem[1] = 8'h00; act_mem[2] = 8'h0F; act_mem[3] = 8'hAA;
    wgt_mem[0] = 8'hFF; wgt_mem[1] = 8'hFF; wgt_mem[2] = 8'h0F; wgt_mem[3] = 8'h55;

    sys_rst_n     = 1'b0;
    start         = 1'b0;
    length        = '0;
    act_base      = '0;
    wgt_base      = '0;
    threshold_cfg = '0;
    result_in     = '0;
    result_valid  = 1'b0;
    act_rd_data   = '0;
    wgt_rd_data   = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_ctrl_outputs",
        {19'd0, act_rd_en, wgt_rd_en, beat_valid, threshold_valid, busy, done, err, result_bit},
        32'd0);
    chk("reset_addrs", {act_rd_addr, wgt_rd_addr}, 32'd0);
    chk("reset_bytes", {activ_out, weight_out, in_length_out}, 32'd0);
    chk("reset_threshold", threshold_out, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(jobs[i]);
      if (i == 3) begin
        for (int k = 0; k < 4; k++) chk("wrap_addr_seq", addr_log[k], wrap_exp[k]);
      end
    end

    // Reset in the middle of FETCH, with a beat already on the output.
    @(posedge sys_clk); #1;
    start = 1'b1; length = 16'd8; act_base = '0; wgt_base = '0; threshold_cfg = 32'd55;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("pre_abort_beat", beat_valid, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_ctrl_outputs",
        {19'd0, act_rd_en, wgt_rd_en, beat_valid, threshold_valid, busy, done, err, result_bit},
        32'd0);
    chk("abort_addrs", {act_rd_addr, wgt_rd_addr}, 32'd0);
    chk("abort_bytes", {activ_out, weight_out, in_length_out}, 32'd0);
    chk("abort_threshold", threshold_out, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n  = 1'b1;
    abort_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (done || busy || beat_valid || act_rd_en) abort_done++;
    end
    chk("abort_no_activity", abort_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
